// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam int unsigned DEF_N_REQ          = 4;
    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// N-requester round-robin front end for a single APB master port.
// Optional ACCESS-phase PREADY timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = DEF_N_REQ,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]           req_done,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, grant_idx, grant_q;
    logic [N_REQ-1:0] grant_oh, grant_oh_q;
    logic             tmo_hit;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle; PREADY=1 on that cycle still wins.
    assign tmo_hit = (state == ACCESS) && !PREADY &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == ACCESS && !PREADY)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        req_done   = '0;
        case (state)
            IDLE:   if (|req_valid) state_next = SETUP;
            SETUP: begin
                PSEL       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || tmo_hit) state_next = DONE;
            end
            DONE: begin
                req_done   = grant_oh_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr        <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && |req_valid) begin
                grant_q    <= grant_idx;
                grant_oh_q <= grant_oh;
                PWRITE     <= req_write[grant_idx];
                PADDR      <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                PWDATA     <= req_wdata[grant_idx*DATA_W +: DATA_W];
            end
            if (state == ACCESS && PREADY) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (tmo_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
            if (state == DONE)
                ptr <= (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table plus hand-written reset, round-robin
// and timeout sequences; completions are checked against a scoreboard queue.
module tb_apb_req_arbiter;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic [3:0]   req_valid, req_write, req_done;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  rsp_rdata, PADDR, PWDATA, PRDATA;
    logic         rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    apb_req_arbiter #(
        .N_REQ          (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        drop;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;
    vec_t tbl[6];
    vec_t tmo_vec;
    bit   got_m;
    int   rr_times[5];
    int   rr_n;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard side: every completion pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (PRESET !== 1'b1 && req_done !== 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(req_done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_done_vec", 64'(req_done), 64'(4'b1 << mon_e.idx));
                check("sb_rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                check("sb_rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    task automatic do_txn(input vec_t v);
        bit   got;
        int   acc;
        exp_t e;
        req_addr  = {$urandom, $urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_write = 4'($urandom);
        req_addr[v.req*32 +: 32]  = v.addr;
        req_wdata[v.req*32 +: 32] = v.wdata;
        req_write[v.req]          = v.wr;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        e.idx   = v.req;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        req_valid        = 4'b0;
        req_valid[v.req] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("setup_seen", 64'(got), 64'd1);
        if (!got) begin
            req_valid = '0;
            return;
        end
        check("setup_paddr", 64'(PADDR), 64'(v.addr));
        check("setup_pwrite", 64'(PWRITE), 64'(v.wr));
        check("setup_pwdata", 64'(PWDATA), 64'(v.wdata));
        if (v.drop) req_valid[v.req] = 1'b0;
        acc = 0;
        @(negedge PCLK);
        // Wait cycles present a slave error and junk data that must not be captured.
        while (PSEL === 1'b1 && PENABLE === 1'b1 && acc < 40) begin
            acc++;
            check("access_paddr", 64'(PADDR), 64'(v.addr));
            if (acc > v.waits) begin
                PREADY  = 1'b1;
                PSLVERR = v.slverr;
                PRDATA  = v.prdata;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b1;
                PRDATA  = 32'hDEAD_BEEF;
            end
            @(negedge PCLK);
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        check("access_len", 64'(acc), 64'(v.exp_acc));
        check("done_now", 64'(req_done), 64'(4'b1 << v.req));
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{req:0, wr:1'b1, addr:32'h10,        wdata:32'hA5A5_0001, waits:0, prdata:32'h1111_1111,
                   slverr:1'b0, drop:1'b0, exp_acc:1, exp_rdata:32'h0,         exp_err:1'b0};
        tbl[1] = '{req:2, wr:1'b0, addr:32'h200,       wdata:32'h0000_0002, waits:3, prdata:32'h1234_5678,
                   slverr:1'b0, drop:1'b0, exp_acc:4, exp_rdata:32'h1234_5678, exp_err:1'b0};
        tbl[2] = '{req:1, wr:1'b1, addr:32'h44,        wdata:32'hBEEF_0044, waits:0, prdata:32'h0000_0009,
                   slverr:1'b1, drop:1'b0, exp_acc:1, exp_rdata:32'h0,         exp_err:1'b1};
        tbl[3] = '{req:3, wr:1'b0, addr:32'h3C,        wdata:32'h0000_0005, waits:2, prdata:32'hCAFE_F00D,
                   slverr:1'b0, drop:1'b0, exp_acc:3, exp_rdata:32'hCAFE_F00D, exp_err:1'b0};
        tbl[4] = '{req:1, wr:1'b0, addr:32'h80,        wdata:32'h0000_0007, waits:0, prdata:32'h0000_55AA,
                   slverr:1'b1, drop:1'b0, exp_acc:1, exp_rdata:32'h0000_55AA, exp_err:1'b1};
        tbl[5] = '{req:0, wr:1'b1, addr:32'hFFFF_FFFC, wdata:32'hFFFF_FFFF, waits:1, prdata:32'h2222_2222,
                   slverr:1'b0, drop:1'b1, exp_acc:2, exp_rdata:32'h0,         exp_err:1'b0};
`ifdef APB_ARB_TIMEOUT_EN
        tmo_vec = '{req:1, wr:1'b0, addr:32'h300, wdata:32'h0, waits:100, prdata:32'h0000_ABCD,
                    slverr:1'b0, drop:1'b0, exp_acc:16, exp_rdata:32'h0, exp_err:1'b1};
`else
        tmo_vec = '{req:1, wr:1'b0, addr:32'h300, wdata:32'h0, waits:20, prdata:32'h0000_ABCD,
                    slverr:1'b0, drop:1'b0, exp_acc:21, exp_rdata:32'h0000_ABCD, exp_err:1'b0};
`endif

        PRESET    = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        #2 PRESET = 1'b1;
        @(negedge PCLK);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_req_done", 64'(req_done), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        req_valid = 4'hF;
        @(negedge PCLK);
        check("rst_no_grant", 64'(PSEL), 64'd0);
        req_valid = '0;
        PRESET    = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // Reset during ACCESS: bus drops at once and the aborted transfer never completes.
        req_valid = 4'b0100;
        req_write = '0;
        req_addr[64 +: 32] = 32'h500;
        got_m = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                got_m = 1'b1;
                break;
            end
        end
        check("rst_mid_setup", 64'(got_m), 64'd1);
        @(negedge PCLK);
        check("rst_mid_access", 64'(PENABLE), 64'd1);
        #2 PRESET = 1'b1;
        #1;
        check("rst_mid_psel", 64'(PSEL), 64'd0);
        check("rst_mid_penable", 64'(PENABLE), 64'd0);
        check("rst_mid_paddr", 64'(PADDR), 64'd0);
        check("rst_mid_done", 64'(req_done), 64'd0);
        req_valid = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (6) @(negedge PCLK);
        check("rst_mid_no_done", 64'(req_done), 64'd0);

        // All requesters active: grants 0,1,2,3,0 from the reset pointer, 4 cycles apart.
        req_write = '0;
        PRDATA    = 32'h7777_0000;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_e.idx   = k % 4;
            push_e.rdata = 32'h7777_0000;
            push_e.err   = 1'b0;
            sb.push_back(push_e);
        end
        req_valid = 4'hF;
        rr_n = 0;
        for (int i = 0; i < 60 && rr_n < 5; i++) begin
            @(negedge PCLK);
            if (req_done !== 4'b0) begin
                rr_times[rr_n] = cyc;
                rr_n++;
            end
        end
        req_valid = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        check("rr_count", 64'(rr_n), 64'd5);
        for (int k = 1; k < 5; k++) begin
            if (k < rr_n) check("rr_spacing", 64'(rr_times[k] - rr_times[k-1]), 64'd4);
        end
        @(negedge PCLK);

        do_txn(tmo_vec);

        repeat (3) @(negedge PCLK);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
